// File: rtl/abc_input_debouncer.sv
// Three-channel two-flop synchronizer and stability debouncer for the A/B/C operands.
// Optional per-channel rise/fall pulses are enabled with ABC_DEBOUNCE_EDGE_PULSE_EN.
module abc_input_debouncer #(
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic       raw_c,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       changed
`ifdef ABC_DEBOUNCE_EDGE_PULSE_EN
  ,
  output logic [2:0] rise,
  output logic [2:0] fall
`endif
);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > ((1 << CNT_W) - 1)) begin : g_bad_stable_cycles
    $error("abc_input_debouncer: STABLE_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  // Channel vectors use bit 2 = A, bit 1 = B, bit 0 = C throughout.
  logic [2:0]       raw;
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       level;
  logic [2:0]       upd;
  state_t           state [3];
  logic [CNT_W-1:0] cnt   [3];

  assign raw       = {raw_a, raw_b, raw_c};
  assign {a, b, c} = level;

  // A channel accepts its new level on the last cycle of an unbroken CHECK run.
  always_comb begin
    upd = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (state[i] == CHECK && s2[i] != level[i] && cnt[i] == LAST) begin
        upd[i] = 1'b1;
      end else begin
        upd[i] = 1'b0;
      end
    end
  end

  // Synchronizers, per-channel debounce FSMs and registered update pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 3'b000;
      s2      <= 3'b000;
      level   <= 3'b000;
      changed <= 1'b0;
`ifdef ABC_DEBOUNCE_EDGE_PULSE_EN
      rise    <= 3'b000;
      fall    <= 3'b000;
`endif
      for (int i = 0; i < 3; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= {CNT_W{1'b0}};
      end
    end else begin
      s1      <= raw;
      s2      <= s1;
      changed <= |upd;
`ifdef ABC_DEBOUNCE_EDGE_PULSE_EN
      rise    <= upd & s2;
      fall    <= upd & ~s2;
`endif
      for (int i = 0; i < 3; i++) begin
        case (state[i])
          STABLE: begin
            if (s2[i] != level[i]) begin
              state[i] <= CHECK;
              cnt[i]   <= CNT_W'(1);
            end else begin
              state[i] <= STABLE;
              cnt[i]   <= {CNT_W{1'b0}};
            end
          end
          CHECK: begin
            if (s2[i] == level[i]) begin
              state[i] <= STABLE;
              cnt[i]   <= {CNT_W{1'b0}};
            end else if (upd[i]) begin
              level[i] <= s2[i];
              state[i] <= STABLE;
              cnt[i]   <= {CNT_W{1'b0}};
            end else begin
              state[i] <= CHECK;
              cnt[i]   <= cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state[i] <= STABLE;
            cnt[i]   <= {CNT_W{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_abc_input_debouncer.sv
// Scoreboard bench for abc_input_debouncer: a sliding-window history model predicts
// every cycle's outputs; a monitor compares levels each cycle and update events on changed.
module tb_abc_input_debouncer;
  localparam int N  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset, raw_a, raw_b, raw_c;
  logic a, b, c, changed;
`ifdef ABC_DEBOUNCE_EDGE_PULSE_EN
  logic [2:0] rise, fall;
`endif

  always #5 clk = ~clk;

  abc_input_debouncer #(.CNT_W(CW), .STABLE_CYCLES(N)) dut (
    .clk(clk), .reset(reset), .raw_a(raw_a), .raw_b(raw_b), .raw_c(raw_c),
    .a(a), .b(b), .c(c), .changed(changed)
`ifdef ABC_DEBOUNCE_EDGE_PULSE_EN
    , .rise(rise), .fall(fall)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [3:0] lvlq[$];   // expected {a,b,c,changed} per edge
  logic [8:0] evq[$];    // expected {a,b,c,rise,fall} per update event
  bit   [2:0] rawh[$];   // raw level presented at each edge
  bit         rsth[$];   // reset presented at each edge
  bit   [2:0] seenh[$];  // synchronized level the debouncer sees at each edge
  bit   [2:0] mout = 3'b000;
  int         last_ev[3] = '{0, 0, 0};

  // Reference: a channel adopts a level once its last N synchronized samples all
  // differ from the current output, counting only samples after the last reset/update.
  function automatic void model_edge(input bit r, input bit [2:0] rv);
    int k;
    bit [2:0] seen, upd;
    bit ok;
    k = rawh.size();
    rawh.push_back(rv);
    rsth.push_back(r);
    if (k < 2) seen = 3'b000;
    else if (rsth[k-1] || rsth[k-2]) seen = 3'b000;
    else seen = rawh[k-2];
    seenh.push_back(seen);
    upd = 3'b000;
    if (r) begin
      mout = 3'b000;
      for (int i = 0; i < 3; i++) last_ev[i] = k;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (k - last_ev[i] >= N) begin
          ok = 1'b1;
          for (int j = k - N + 1; j <= k; j++)
            if (seenh[j][i] == mout[i]) ok = 1'b0;
          upd[i] = ok;
          if (ok) last_ev[i] = k;
        end
      end
      mout = mout ^ upd;
    end
    lvlq.push_back({mout, |upd});
    if (|upd) evq.push_back({mout, upd & seen, upd & ~seen});
  endfunction

  task automatic step(input bit r, input bit [2:0] rv);
    reset = r;
    {raw_a, raw_b, raw_c} = rv;
    model_edge(r, rv);
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input bit [2:0] rv, input int n);
    for (int i = 0; i < n; i++) step(1'b0, rv);
  endtask

  // Monitor: compares each edge's levels and pops an event whenever changed pulses.
  initial begin
    logic [3:0] el;
    logic [8:0] ee, got;
    forever begin
      @(posedge clk);
      @(negedge clk);
      if (lvlq.size() != 0) begin
        el = lvlq.pop_front();
        checks++;
        if ({a, b, c, changed} !== el) begin
          failures++;
          $display("FAIL level t=%0t got abc_chg=%b expected %b", $time, {a, b, c, changed}, el);
        end
      end
      if (changed === 1'b1) begin
        checks++;
        if (evq.size() == 0) begin
          failures++;
          $display("FAIL event t=%0t got changed pulse with abc=%b, expected no update", $time, {a, b, c});
        end else begin
          ee = evq.pop_front();
`ifdef ABC_DEBOUNCE_EDGE_PULSE_EN
          got = {a, b, c, rise, fall};
`else
          got = {a, b, c, ee[5:0]};
`endif
          if (got !== ee) begin
            failures++;
            $display("FAIL event t=%0t got abc_rise_fall=%b expected %b", $time, got, ee);
          end
        end
      end
    end
  end

  initial begin
    int hcnt[3];
    bit [2:0] lvl;
    // Reset with raw high, then settle low
    step(1'b1, 3'b111);
    step(1'b1, 3'b111);
    hold(3'b000, 8);
    // B rises and is held
    hold(3'b010, 10);
    // A pulse shorter than the stability window
    hold(3'b110, 3);
    hold(3'b010, 8);
    // A and C rise together
    hold(3'b111, 10);
    // C falls, then rises and is interrupted by reset mid-count
    hold(3'b110, 10);
    hold(3'b111, 3);
    step(1'b1, 3'b111);
    hold(3'b111, 12);
    // B falls and is held
    hold(3'b101, 10);
    // Random bouncing with occasional resets
    lvl = 3'b101;
    hcnt = '{0, 0, 0};
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (hcnt[i] == 0) begin
          lvl[i] = ~lvl[i];
          hcnt[i] = ($urandom_range(9, 0) < 7) ? int'($urandom_range(3, 1)) : int'($urandom_range(12, 5));
        end
        hcnt[i]--;
      end
      step(($urandom_range(149, 0) == 0), lvl);
    end
    hold(lvl, 12);
    @(negedge clk);
    #1;
    checks++;
    if (evq.size() != 0) begin
      failures++;
      $display("FAIL missing_events got %0d pending expected 0", evq.size());
    end
    checks++;
    if (lvlq.size() != 0) begin
      failures++;
      $display("FAIL unchecked_levels got %0d pending expected 0", lvlq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
